// File: rtl/quant8x8_tbl.sv
// ---------------------------------------------------------------------------
// quant8x8_tbl
//
// 8x8 coefficient quantizer with two run-time loadable reciprocal tables
// (table 0 = luma, table 1 = chroma). A block arrives as 8 consecutive row
// beats of 8 coefficients, starting with the qut_go_i beat. Each coefficient
// is multiplied by its table reciprocal, rounded half-away-from-zero, and
// saturated to OUT_W bits. Rows leave in input order, 2 cycles after capture.
//
// Ports
//   clk_i        clock, rising edge
//   rst_i        synchronous active-high reset (pipeline, outputs, tables)
//   qut_go_i     pulse marking row 0 of a block (also aborts a block in flight)
//   tbl_sel_i    table select, sampled with qut_go_i
//   data_in_i    row beat, lane k at [k*COEF_W +: COEF_W]
//   qt_we_i      table write strobe (ignored while busy_o or qut_go_i)
//   qt_addr_i    {table, row[2:0], col[2:0]}
//   qt_data_i    reciprocal, round(2^RECIP_W / Q)
//   data_out_o   quantized row, lane k at [k*OUT_W +: OUT_W]
//   out_valid_o  data_out_o valid
//   out_first_o  row 0 of an output block
//   qut_done_o   pulse with row 7 of a completed block
//   sat_o        some lane of the block clamped; valid with qut_done_o
//   busy_o       block in capture or in the pipeline
//
// Contains quant8x8_lane (per-lane datapath) and the top quant8x8_tbl.
// ---------------------------------------------------------------------------

// ---------------------------------------------------------------------------
// quant8x8_lane: one coefficient lane.
//   ld    : capture coef*recip into the product register (stage 1)
//   v1    : stage 1 holds a valid product; load stage 2
//   q     : registered rounded/saturated result (stage 2)
//   sat   : combinational clamp flag for the product currently in stage 1
// ---------------------------------------------------------------------------
module quant8x8_lane #(
  parameter int COEF_W  = 32,
  parameter int OUT_W   = 16,
  parameter int RECIP_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ld,
  input  logic               v1,
  input  logic [COEF_W-1:0]  coef,
  input  logic [RECIP_W-1:0] recip,
  output logic [OUT_W-1:0]   q,
  output logic               sat
);
  localparam int PW = COEF_W + RECIP_W + 1;

  localparam logic [PW-1:0] HALF    = {{(PW-RECIP_W){1'b0}}, 1'b1, {(RECIP_W-1){1'b0}}};
  localparam logic [PW-1:0] MAX_POS = {{(PW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  // Negative side reaches one further: magnitude 2^(OUT_W-1) is exact.
  localparam logic [PW-1:0] MAX_NEG = MAX_POS + PW'(1);

  localparam logic [OUT_W-1:0] OUT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] OUT_MIN = {1'b1, {(OUT_W-1){1'b0}}};

  logic signed [PW-1:0] prod_d, prod_q;
  logic [PW-1:0]        mag, rnd, m;
  logic                 neg, pos_ovf, neg_ovf;
  logic [OUT_W-1:0]     qd;

  // Reciprocal is unsigned: zero-extend it before the signed multiply.
  always_comb prod_d = PW'($signed(coef)) * PW'($signed({1'b0, recip}));

  always_ff @(posedge clk) begin
    if (rst)     prod_q <= '0;
    else if (ld) prod_q <= prod_d;
  end

  // Round on the magnitude so ties move away from zero, then reapply sign.
  always_comb begin
    neg     = prod_q[PW-1];
    mag     = neg ? $unsigned(-prod_q) : $unsigned(prod_q);
    rnd     = mag + HALF;
    m       = rnd >> RECIP_W;
    pos_ovf = !neg && (m > MAX_POS);
    neg_ovf =  neg && (m > MAX_NEG);
    sat     = pos_ovf | neg_ovf;
    if (pos_ovf)      qd = OUT_MAX;
    else if (neg_ovf) qd = OUT_MIN;
    else if (neg)     qd = -m[OUT_W-1:0];
    else              qd = m[OUT_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst)     q <= '0;
    else if (v1) q <= qd;
  end
endmodule

// ---------------------------------------------------------------------------
// quant8x8_tbl: top level. Capture FSM, reciprocal tables, pipeline
// sideband (valid/first/last) and per-block saturation accumulation.
// ---------------------------------------------------------------------------
module quant8x8_tbl #(
  parameter int COEF_W  = 32,
  parameter int OUT_W   = 16,
  parameter int RECIP_W = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 qut_go_i,
  input  logic                 tbl_sel_i,
  input  logic [8*COEF_W-1:0]  data_in_i,
  input  logic                 qt_we_i,
  input  logic [6:0]           qt_addr_i,
  input  logic [RECIP_W-1:0]   qt_data_i,
  output logic [8*OUT_W-1:0]   data_out_o,
  output logic                 out_valid_o,
  output logic                 out_first_o,
  output logic                 qut_done_o,
  output logic                 sat_o,
  output logic                 busy_o
);
  localparam int NUM_LANES = 8;
  localparam int STAGES    = 2;

  typedef enum logic {IDLE, CAPT} state_t;

  typedef struct packed {
    logic first;
    logic last;
  } side_t;

  state_t state;
  logic [2:0] rcnt;      // row expected on the current beat while in CAPT
  logic       tbl_q;     // table latched at go

  logic [1:0][63:0][RECIP_W-1:0] tbl;

  logic [NUM_LANES-1:0][COEF_W-1:0]  coef;
  logic [NUM_LANES-1:0][RECIP_W-1:0] recip;
  logic [NUM_LANES-1:0][OUT_W-1:0]   lane_q;
  logic [NUM_LANES-1:0]              lane_sat;

  logic              accept, cur_tbl;
  logic [2:0]        cur_row;
  side_t             side_in;
  logic [STAGES:1]   vld_pipe;
  side_t [STAGES:1]  side_pipe;
  logic              sat_acc, sat_next;

  // No per-beat valid: every cycle of a go or of CAPT is a row beat.
  // The go beat itself is row 0 and must use the incoming table select.
  always_comb begin
    accept        = qut_go_i | (state == CAPT);
    cur_tbl       = qut_go_i ? tbl_sel_i : tbl_q;
    cur_row       = qut_go_i ? 3'd0 : rcnt;
    side_in.first = qut_go_i;
    side_in.last  = !qut_go_i && (state == CAPT) && (rcnt == 3'd7);
  end

  assign coef = data_in_i;

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    assign recip[k] = tbl[cur_tbl][{cur_row, 3'(k)}];

    quant8x8_lane #(
      .COEF_W  (COEF_W),
      .OUT_W   (OUT_W),
      .RECIP_W (RECIP_W)
    ) u_lane (
      .clk   (clk_i),
      .rst   (rst_i),
      .ld    (accept),
      .v1    (vld_pipe[1]),
      .coef  (coef[k]),
      .recip (recip[k]),
      .q     (lane_q[k]),
      .sat   (lane_sat[k])
    );
  end

  // A new block's row 0 restarts the accumulator, so an aborted block's
  // clamps never leak into its successor.
  always_comb sat_next = (side_pipe[1].first ? 1'b0 : sat_acc) | (|lane_sat);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= IDLE;
      rcnt      <= '0;
      tbl_q     <= 1'b0;
      vld_pipe  <= '0;
      side_pipe <= '0;
      sat_acc   <= 1'b0;
      sat_o     <= 1'b0;
      busy_o    <= 1'b0;
    end else begin
      if (qut_go_i) begin
        state <= CAPT;
        rcnt  <= 3'd1;
        tbl_q <= tbl_sel_i;
      end else if (state == CAPT) begin
        rcnt <= rcnt + 3'd1;
        if (rcnt == 3'd7) state <= IDLE;
      end

      vld_pipe  <= {vld_pipe[STAGES-1:1], accept};
      side_pipe <= {side_pipe[STAGES-1:1], side_in};

      if (vld_pipe[1]) sat_acc <= sat_next;
      sat_o  <= vld_pipe[1] & side_pipe[1].last & sat_next;
      busy_o <= accept | vld_pipe[1];
    end
  end

  // Tables: all-ones (~Q=1) out of reset; writes blocked while a block is
  // live so the reciprocals under a block never change mid-flight.
  always_ff @(posedge clk_i) begin
    if (rst_i)
      tbl <= '1;
    else if (qt_we_i && !busy_o && !qut_go_i)
      tbl[qt_addr_i[6]][qt_addr_i[5:0]] <= qt_data_i;
  end

  assign data_out_o  = lane_q;
  assign out_valid_o = vld_pipe[STAGES];
  assign out_first_o = side_pipe[STAGES].first;
  assign qut_done_o  = side_pipe[STAGES].last;
endmodule

// File: tb/tb_quant8x8_tbl.sv
// ---------------------------------------------------------------------------
// tb_quant8x8_tbl: scoreboard bench for quant8x8_tbl. The stimulus pushes the
// hand-computed expected row (data, first, done, sat, arrival cycle) for each
// beat; an independent monitor pops and compares whenever out_valid_o is high.
// ---------------------------------------------------------------------------
module tb_quant8x8_tbl;
  localparam int COEF_W  = 32;
  localparam int OUT_W   = 16;
  localparam int RECIP_W = 16;

  logic                clk = 1'b0;
  logic                rst_i;
  logic                qut_go_i;
  logic                tbl_sel_i;
  logic [8*COEF_W-1:0] data_in_i;
  logic                qt_we_i;
  logic [6:0]          qt_addr_i;
  logic [RECIP_W-1:0]  qt_data_i;
  logic [8*OUT_W-1:0]  data_out_o;
  logic                out_valid_o, out_first_o, qut_done_o, sat_o, busy_o;

  always #5 clk = ~clk;

  quant8x8_tbl #(.COEF_W(COEF_W), .OUT_W(OUT_W), .RECIP_W(RECIP_W)) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .qut_go_i    (qut_go_i),
    .tbl_sel_i   (tbl_sel_i),
    .data_in_i   (data_in_i),
    .qt_we_i     (qt_we_i),
    .qt_addr_i   (qt_addr_i),
    .qt_data_i   (qt_data_i),
    .data_out_o  (data_out_o),
    .out_valid_o (out_valid_o),
    .out_first_o (out_first_o),
    .qut_done_o  (qut_done_o),
    .sat_o       (sat_o),
    .busy_o      (busy_o)
  );

  typedef struct {
    logic [8*OUT_W-1:0] data;
    logic               first;
    logic               done;
    logic               sat;
    int                 cyc;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [8*COEF_W-1:0] pack_in(input int c[8]);
    logic [8*COEF_W-1:0] r;
    for (int k = 0; k < 8; k++) r[k*COEF_W +: COEF_W] = COEF_W'(c[k]);
    return r;
  endfunction

  function automatic logic [8*OUT_W-1:0] pack_out(input int e[8]);
    logic [8*OUT_W-1:0] r;
    for (int k = 0; k < 8; k++) r[k*OUT_W +: OUT_W] = e[k][OUT_W-1:0];
    return r;
  endfunction

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: compares every output beat against the scoreboard head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (out_valid_o === 1'b1) begin
        n_chk++;
        if (q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_valid cyc=%0d: got data=%h with no row expected", cyc, data_out_o);
        end else begin
          e = q.pop_front();
          if (data_out_o !== e.data || out_first_o !== e.first || qut_done_o !== e.done ||
              sat_o !== e.sat || cyc != e.cyc) begin
            n_fail++;
            $display("FAIL row_out: got cyc=%0d data=%h first=%b done=%b sat=%b; expected cyc=%0d data=%h first=%b done=%b sat=%b",
                     cyc, data_out_o, out_first_o, qut_done_o, sat_o, e.cyc, e.data, e.first, e.done, e.sat);
          end
        end
      end else if (out_valid_o === 1'b0) begin
        n_chk++;
        if (qut_done_o !== 1'b0 || out_first_o !== 1'b0 || sat_o !== 1'b0) begin
          n_fail++;
          $display("FAIL idle_flags cyc=%0d: got done=%b first=%b sat=%b expected 0", cyc, qut_done_o, out_first_o, sat_o);
        end
      end
    end
  end

  task automatic write_tbl(input logic tsel, input logic [RECIP_W-1:0] val);
    for (int i = 0; i < 64; i++) begin
      qt_we_i = 1'b1; qt_addr_i = {tsel, 6'(i)}; qt_data_i = val;
      @(negedge clk);
    end
    qt_we_i = 1'b0;
  endtask

  // Drives nrows beats of a block; the first npush beats are expected to
  // emerge. Row alt_row uses ac/ae; at row we_row a table-1 write is attempted.
  task automatic send_block(input int c[8], input int e[8], input bit sel, input bit exp_sat,
                            input int nrows, input int npush, input int alt_row,
                            input int ac[8], input int ae[8], input int we_row);
    exp_t x;
    for (int r = 0; r < nrows; r++) begin
      qut_go_i  = (r == 0);
      tbl_sel_i = (r == 0) ? sel : !sel;   // must be ignored after go
      if (r == alt_row) begin
        data_in_i = pack_in(ac); x.data = pack_out(ae);
      end else begin
        data_in_i = pack_in(c);  x.data = pack_out(e);
      end
      if (r == we_row) begin
        qt_we_i = 1'b1; qt_addr_i = 7'h40; qt_data_i = '1;
      end
      if (r < npush) begin
        x.first = (r == 0);
        x.done  = (r == 7);
        x.sat   = (r == 7) && exp_sat;
        x.cyc   = cyc + 2;
        q.push_back(x);
      end
      @(negedge clk);
      qut_go_i = 1'b0;
      qt_we_i  = 1'b0;
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 50 && (busy_o !== 1'b0 || q.size() != 0); i++) @(negedge clk);
    n_chk++;
    if (busy_o !== 1'b0 || q.size() != 0) begin
      n_fail++;
      $display("FAIL idle_timeout: got busy=%b pending=%0d expected busy=0 pending=0", busy_o, q.size());
    end
  endtask

  initial begin
    int pa[8], ea[8], pb[8], eb[8], xa[8], xe[8];
    rst_i = 1'b1; qut_go_i = 1'b0; tbl_sel_i = 1'b0; data_in_i = '0;
    qt_we_i = 1'b0; qt_addr_i = '0; qt_data_i = '0;
    repeat (3) @(negedge clk);
    check("rst_data",  data_out_o, 0);
    check("rst_valid", out_valid_o, 0);
    check("rst_first", out_first_o, 0);
    check("rst_done",  qut_done_o, 0);
    check("rst_sat",   sat_o, 0);
    check("rst_busy",  busy_o, 0);
    rst_i = 1'b0;
    @(negedge clk);

    // Table 0 = 4096 (Q=16): 100 -> 6.25 -> 6
    write_tbl(1'b0, 16'd4096);
    pa = '{100, 100, 100, 100, 100, 100, 100, 100};
    ea = '{6, 6, 6, 6, 6, 6, 6, 6};
    send_block(pa, ea, 1'b0, 1'b0, 8, 8, -1, pa, ea, -1);
    check("busy_t8",  busy_o, 1);
    @(negedge clk);
    check("busy_t9",  busy_o, 1);
    @(negedge clk);
    check("busy_t10", busy_o, 0);

    // Rounding ties away from zero: +-1.5 -> +-2, 0.5 -> 1, 0.4375 -> 0
    pa = '{-24, 24, 8, 7, -8, -7, 0, 100};
    ea = '{-2, 2, 1, 0, -1, 0, 0, 6};
    send_block(pa, ea, 1'b0, 1'b0, 8, 8, -1, pa, ea, -1);

    // Default table 1 (all-ones): exact boundaries 32767 / -32768, no clamp
    pa = '{32767, -32768, 1, -1, 0, 2, -2, 1000};
    ea = '{32767, -32768, 1, -1, 0, 2, -2, 1000};
    send_block(pa, ea, 1'b1, 1'b0, 8, 8, -1, pa, ea, -1);
    // Same, with one clamping row (5) -> sat at done
    xa = '{1 << 20, -(1 << 20), 32768, -32770, 7, -7, 0, 0};
    xe = '{32767, -32768, 32767, -32768, 7, -7, 0, 0};
    send_block(pa, ea, 1'b1, 1'b1, 8, 8, 5, xa, xe, -1);
    wait_idle();

    // Table 1 = 2048 (Q=32); back-to-back blocks, blocked writes at t+3 and at go
    write_tbl(1'b1, 16'd2048);
    pa = '{100, -100, 48, -48, 16, -16, 15, 0};
    ea = '{3, -3, 2, -2, 1, -1, 0, 0};
    pb = '{-100, 100, -48, 48, -16, 16, -15, 0};
    eb = '{-3, 3, -2, 2, -1, 1, 0, 0};
    send_block(pa, ea, 1'b1, 1'b0, 8, 8, -1, pa, ea, 3);
    send_block(pb, eb, 1'b1, 1'b0, 8, 8, -1, pb, eb, 0);
    wait_idle();
    send_block(pa, ea, 1'b1, 1'b0, 8, 8, -1, pa, ea, -1);   // readback
    wait_idle();

    // Restart at t+3: old rows 0..2 (row 1 clamps) emerge without done
    pa = '{1000, 1000, 1000, 1000, 1000, 1000, 1000, 1000};
    ea = '{63, 63, 63, 63, 63, 63, 63, 63};
    xa = '{1 << 20, 1 << 20, 1 << 20, 1 << 20, 1 << 20, 1 << 20, 1 << 20, 1 << 20};
    xe = '{32767, 32767, 32767, 32767, 32767, 32767, 32767, 32767};
    send_block(pa, ea, 1'b0, 1'b0, 3, 3, 1, xa, xe, -1);
    pb = '{-1000, -1000, -1000, -1000, -1000, -1000, -1000, -1000};
    eb = '{-63, -63, -63, -63, -63, -63, -63, -63};
    send_block(pb, eb, 1'b0, 1'b0, 8, 8, -1, pb, eb, -1);
    wait_idle();

    // Reset at t+4: rows 0..2 emerge, then everything clears
    pa = '{100, 100, 100, 100, 100, 100, 100, 100};
    ea = '{6, 6, 6, 6, 6, 6, 6, 6};
    send_block(pa, ea, 1'b0, 1'b0, 4, 3, -1, pa, ea, -1);
    rst_i = 1'b1;
    @(negedge clk);
    rst_i = 1'b0;
    check("mid_rst_data",  data_out_o, 0);
    check("mid_rst_valid", out_valid_o, 0);
    check("mid_rst_done",  qut_done_o, 0);
    check("mid_rst_busy",  busy_o, 0);
    check("mid_rst_queue", q.size(), 0);
    @(negedge clk);

    // Table 0 back to all-ones
    pa = '{1, -1, 5, -5, 100, -100, 0, 3};
    ea = '{1, -1, 5, -5, 100, -100, 0, 3};
    send_block(pa, ea, 1'b0, 1'b0, 8, 8, -1, pa, ea, -1);
    wait_idle();
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/quant8x8_tbl.md
# quant8x8_tbl

Parametrised 8x8 coefficient quantizer with two run-time loadable quantization tables (luma/chroma), selected per block. It sits between `dct8x8` and the entropy stage. It accepts one block as 8 consecutive row beats of 8 DCT coefficients. Each coefficient is multiplied by a stored reciprocal, rounded half-away-from-zero and saturated. Results are emitted row-by-row in input order, through a 2-stage pipeline.

## Interface
- COEF_W, 32, signed input coefficient width
- OUT_W, 16, signed output coefficient width
- RECIP_W, 16, unsigned reciprocal width; entry = round(2^RECIP_W / Q)
- clk_i  in  1  clock, all logic on rising edge
- rst_i  in  1  reset; one clock; reset is synchronous and active-high
- qut_go_i  in  1  single-cycle pulse marking row 0 of a block
- tbl_sel_i  in  1  table select (0 luma, 1 chroma), sampled with qut_go_i
- data_in_i  in  8*COEF_W  row beat; lane k = column k at [k*COEF_W +: COEF_W]
- qt_we_i  in  1  table write strobe
- qt_addr_i  in  7  {table, row[2:0], col[2:0]}
- qt_data_i  in  RECIP_W  reciprocal to write
- data_out_o  out  8*OUT_W  quantized row, same lane order
- out_valid_o  out  1  data_out_o valid
- out_first_o  out  1  marks row 0 of an output block
- qut_done_o  out  1  pulse with row 7 output of a completed block
- sat_o  out  1  any lane of the block saturated; valid with qut_done_o
- busy_o  out  1  block in capture or pipeline

## Operation
- Tables: 2x64 registers, RECIP_W bits each. Reset value of every entry is all-ones (≈Q=1).
- Writes take effect on the next edge. They are ignored when busy_o=1 or qut_go_i=1.
- Capture: qut_go_i at cycle t loads row counter 0. Rows 0..7 are taken unconditionally on cycles t..t+7. There is no per-beat valid.
- Per lane: p = coef * {0,recip}, signed, COEF_W+RECIP_W+1 bits.
- Rounding: m = (|p| + 2^(RECIP_W-1)) >> RECIP_W, then sign is reapplied (half away from zero).
- Saturate to [-2^(OUT_W-1), 2^(OUT_W-1)-1]. Any clamp sets the block's sat flag.
- Table index for row r, lane k = r*8+k, from the table latched at go.
- States: IDLE -> CAPT (row counter 0..7) -> IDLE, or -> CAPT directly on a new go.
- Restart: qut_go_i while in CAPT with row counter 1..7 aborts the old block.
  - Its remaining input beats are dropped.
  - Beats already accepted still emerge with out_valid_o=1.
  - The old block never raises qut_done_o, and its sat flag is discarded.
  - The new block starts at row 0.
- Back-to-back: go at t+8 (the cycle after row 7) is legal, with no bubble.
- Reset mid-block clears all pipeline state and outputs. Tables return to default.

## Timing
- Reset values: data_out_o=0, out_valid_o=0, out_first_o=0, qut_done_o=0, sat_o=0, busy_o=0, state IDLE.
- Stage 1 registers the products (row r at t+r+1). Stage 2 registers the rounded, saturated value.
- Latency is 2 cycles: row r appears at t+r+2.
- out_valid_o is high t+2..t+9. out_first_o is high at t+2.
- qut_done_o and sat_o pulse at t+9, for 1 cycle.
- busy_o is registered: high t+1..t+9, extended if a new go arrives.
- out_valid_o is continuous across back-to-back blocks.

## Test plan
- After reset, load table 0 with all entries 4096 (Q=16). Send a block with every coefficient 100 -> 8 rows of 6, out_first_o at t+2, qut_done_o at t+9, sat_o=0.
- Same table, coefficients -24 and +24 (±1.5 after scaling) -> -2 and +2. Coefficient 8 (0.5) -> 1; coefficient 7 -> 0.
- With the reset table (all-ones), coefficients ±2^20 -> 32767 / -32768, and sat_o=1 at done.
- Load table 1 with entries 2048 and tbl_sel_i=1. Send two blocks back-to-back at t and t+8 -> valid outputs continuous t+2..t+17, two done pulses at t+9 and t+17. Write attempts at t+3 are ignored (readback via a later block is unchanged).
- Second go at t+3 -> old rows 0..2 are emitted at t+2..t+4 with no done. New block row 0 has out_first_o at t+5 and done at t+12.
- Assert rst_i at t+4 -> all outputs 0 next cycle, tables back to all-ones, no done pulse.
